// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one memory port shared by fetch (inst_*) and load/store (data_*).
// Ports: inst_*/data_* requesters, mem_* shared port, flush, busy; one transaction in flight.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                discard_q, discard_d;
  logic [CW-1:0]       starve_q, starve_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [SW-1:0]       wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                gnt_i, gnt_d, rsp;

  // owner_q: 1 = data requester, 0 = fetch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      discard_q <= 1'b0;
      starve_q  <= '0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      wstrb_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      discard_q <= discard_d;
      starve_q  <= starve_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    discard_d = discard_q;
    starve_d  = starve_q;
    wr_d      = wr_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    rsp       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // a flushed fetch is never granted; data takes the slot instead
        gnt_i = resetn && inst_req && !flush &&
                (!data_req || starve_q == SMAX);
        gnt_d = resetn && data_req && !gnt_i;
        if (gnt_i || !inst_req) begin
          starve_d = '0;
        end else if (gnt_d && starve_q != SMAX) begin
          starve_d = starve_q + 1'b1;
        end
        unique case (1'b1)
          gnt_i: begin
            wr_d    = 1'b0;
            size_d  = 2'd2;
            wstrb_d = '0;
            addr_d  = inst_addr;
            wdata_d = '0;
          end
          gnt_d: begin
            wr_d    = data_wr;
            size_d  = data_size;
            wstrb_d = data_wstrb;
            addr_d  = data_addr;
            wdata_d = data_wdata;
          end
          default: ;
        endcase
        if (gnt_i || gnt_d) begin
          state_d   = S_REQ;
          owner_d   = gnt_d;
          discard_d = 1'b0;
        end
      end
      S_REQ: begin
        if (!owner_q && flush) discard_d = 1'b1;
        if (mem_addr_ok) state_d = S_RESP;
      end
      S_RESP: begin
        if (!owner_q && flush) discard_d = 1'b1;
        if (mem_data_ok) begin
          rsp       = 1'b1;
          state_d   = S_IDLE;
          discard_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst_addr_ok = gnt_i;
    data_addr_ok = gnt_d;
    mem_req      = (state_q == S_REQ);
    mem_wr       = mem_req ? wr_q    : 1'b0;
    mem_size     = mem_req ? size_q  : 2'd0;
    mem_wstrb    = mem_req ? wstrb_q : '0;
    mem_addr     = mem_req ? addr_q  : '0;
    mem_wdata    = mem_req ? wdata_q : '0;
    // flush in the response cycle itself also drops the fetch data
    inst_data_ok = rsp && !owner_q && !discard_q && !flush;
    data_data_ok = rsp && owner_q;
    inst_rdata   = inst_data_ok ? mem_rdata : '0;
    data_rdata   = data_data_ok ? mem_rdata : '0;
    busy         = (state_q != S_IDLE);
  end

endmodule
